// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and helpers for the hazard scoreboard: per-stage producer record,
// canonical Tuse/Tnew encodings and the saturating Tnew ageing function.
// Ports: none (package hazard_pkg).
package hazard_pkg;

   localparam int RAW_W = 5;   // register-address width carried in stage_t
   localparam int TW_W  = 2;   // Tuse/Tnew width carried in stage_t

   // One in-flight producer as seen by the scoreboard.
   typedef struct packed {
      logic             vld;
      logic [RAW_W-1:0] dst;
      logic [TW_W-1:0]  tn;
   } stage_t;

   localparam logic [TW_W-1:0] TUSE_NONE = 2'd3;  // operand not read by this instruction
   localparam logic [TW_W-1:0] TNEW_LOAD = 2'd2;  // load result available out of W
   localparam logic [TW_W-1:0] TNEW_ALU  = 2'd1;  // ALU result available out of M

   // One cycle of ageing: Tnew counts down and sticks at zero once the value exists.
   function automatic logic [TW_W-1:0] sat_dec(input logic [TW_W-1:0] t);
      return (t == '0) ? '0 : t - TW_W'(1);
   endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// D-stage decode bundle into the scoreboard and stall/forward decisions back out.
// Ports: d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_tnew, freeze (master drives);
//        stall, fwd_rs_sel, fwd_rt_sel (slave drives).
interface hazard_scoreboard_if
   import hazard_pkg::*;
#(
   parameter int RAW  = RAW_W,
   parameter int TW   = TW_W,
   parameter int SELW = 3
) ();
   logic            d_valid;
   logic [RAW-1:0]  d_rs;
   logic [RAW-1:0]  d_rt;
   logic [TW-1:0]   d_tuse_rs;
   logic [TW-1:0]   d_tuse_rt;
   logic [RAW-1:0]  d_dst;
   logic [TW-1:0]   d_tnew;
   logic            freeze;
   logic            stall;
   logic [SELW-1:0] fwd_rs_sel;
   logic [SELW-1:0] fwd_rt_sel;

   // Decode / pipeline control side.
   modport master (
      output d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_tnew, freeze,
      input  stall, fwd_rs_sel, fwd_rt_sel
   );

   // Scoreboard side.
   modport slave (
      input  d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_tnew, freeze,
      output stall, fwd_rs_sel, fwd_rt_sel
   );
endinterface

// File: rtl/hazard_scoreboard_match.sv
// Newest-producer finder for one source operand: scans the tracked stages and reports
// whether any valid stage writes src, the lowest such stage index k (1-based) and its Tnew.
// Ports: stages (all stage records), src (operand address) -> hit, k, tn. Purely combinational.
module hazard_match
   import hazard_pkg::*;
#(
   parameter int NSTAGE = 3,
   parameter int SELW   = 3
) (
   input  stage_t            stages [NSTAGE],
   input  logic [RAW_W-1:0]  src,
   output logic              hit,
   output logic [SELW-1:0]   k,
   output logic [TW_W-1:0]   tn
);

   // Walk from oldest to youngest so the youngest match overwrites older ones.
   always_comb begin
      hit = 1'b0;
      k   = '0;
      tn  = '0;
      for (int i = NSTAGE - 1; i >= 0; i--) begin
         if (stages[i].vld && (stages[i].dst == src) && (src != '0)) begin
            hit = 1'b1;
            k   = SELW'(i + 1);
            tn  = stages[i].tn;
         end
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Stall/forward scoreboard beside the D/E register: tracks producers through NSTAGE
// post-D stages, ages their Tnew, and drives D-stage stall plus per-operand forward selects.
// Ports: clk, rst_n (async active-low), bus (hazard_scoreboard_if.slave);
//        optional stall_cnt[31:0] when HAZ_STATS_EN is defined (stalled, unfrozen edges).
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int NSTAGE = 3,       // 2..6
   parameter int RAW    = RAW_W,   // must equal the package stage_t widths
   parameter int TW     = TW_W,
   parameter int SELW   = 3        // 2**SELW > NSTAGE
) (
   input  logic                 clk,
   input  logic                 rst_n,
   hazard_scoreboard_if.slave   bus
`ifdef HAZ_STATS_EN
   ,
   output logic [31:0]          stall_cnt
`endif
);

   stage_t stg [NSTAGE];

   logic [RAW-1:0]  rs, rt, dst;
   logic [TW-1:0]   tuse_rs, tuse_rt, tnew;
   logic            hit_rs, hit_rt;
   logic [SELW-1:0] k_rs, k_rt;
   logic [TW-1:0]   tn_rs, tn_rt;
   logic            stall_rs, stall_rt, stall_i;
   logic            entry_vld;

   assign rs      = bus.d_rs;
   assign rt      = bus.d_rt;
   assign dst     = bus.d_dst;
   assign tuse_rs = bus.d_tuse_rs;
   assign tuse_rt = bus.d_tuse_rt;
   assign tnew    = bus.d_tnew;

   hazard_match #(.NSTAGE(NSTAGE), .SELW(SELW)) u_match_rs (
      .stages (stg),
      .src    (rs),
      .hit    (hit_rs),
      .k      (k_rs),
      .tn     (tn_rs)
   );

   hazard_match #(.NSTAGE(NSTAGE), .SELW(SELW)) u_match_rt (
      .stages (stg),
      .src    (rt),
      .hit    (hit_rt),
      .k      (k_rt),
      .tn     (tn_rt)
   );

   // Only the newest producer matters; a not-yet-ready producer with tn <= tuse
   // is left for a later stage to forward, so it neither stalls nor selects.
   assign stall_rs = hit_rs && (tn_rs > tuse_rs);
   assign stall_rt = hit_rt && (tn_rt > tuse_rt);
   assign stall_i  = bus.d_valid && (stall_rs || stall_rt);

   assign bus.stall      = stall_i;
   assign bus.fwd_rs_sel = (bus.d_valid && hit_rs && (tn_rs == '0)) ? k_rs : '0;
   assign bus.fwd_rt_sel = (bus.d_valid && hit_rt && (tn_rt == '0)) ? k_rt : '0;

   // Instructions with no destination are tracked as bubbles.
   assign entry_vld = bus.d_valid && (dst != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NSTAGE; i++) begin
            stg[i] <= '0;
         end
      end else if (!bus.freeze) begin
         for (int i = NSTAGE - 1; i > 0; i--) begin
            stg[i].vld <= stg[i-1].vld;
            stg[i].dst <= stg[i-1].dst;
            stg[i].tn  <= sat_dec(stg[i-1].tn);
         end
         if (stall_i || !entry_vld) begin
            stg[0] <= '0;
         end else begin
            stg[0].vld <= 1'b1;
            stg[0].dst <= dst;
            stg[0].tn  <= tnew;
         end
      end
   end

`ifdef HAZ_STATS_EN
   // Counts bubbles actually inserted; a frozen pipe inserts none.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (stall_i && !bus.freeze) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios then random decode streams, checked
// against a producer-list model (age derived from an advance counter).
// Ports: none.
module tb_hazard_scoreboard;
   import hazard_pkg::*;

   localparam int NSTAGE = 3;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   hazard_scoreboard_if #(.RAW(5), .TW(2), .SELW(3)) bus ();
`ifdef HAZ_STATS_EN
   logic [31:0] stall_cnt;
`endif

   hazard_scoreboard #(.NSTAGE(NSTAGE), .RAW(5), .TW(2), .SELW(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef HAZ_STATS_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   // Reference model: every issued producer with the advance count at which it entered stage 1.
   typedef struct {
      int dst;
      int tnew;
      int entry;
   } prod_t;

   prod_t prods[$];
   int    adv;
   int    m_cnt;
   int    total;
   int    passed;

   task automatic model_reset();
      prods.delete();
      adv   = 0;
      m_cnt = 0;
   endtask

   function automatic void ref_src(input int src, input int tuse, input bit v,
                                   output int st, output int sel);
      int best;
      int tn;
      int s;
      best = NSTAGE + 1;
      tn   = 0;
      st   = 0;
      sel  = 0;
      foreach (prods[i]) begin
         s = adv - prods[i].entry + 1;
         if (src != 0 && prods[i].dst == src && s >= 1 && s <= NSTAGE && s < best) begin
            best = s;
            tn   = prods[i].tnew - (s - 1);
            if (tn < 0) tn = 0;
         end
      end
      if (v && best <= NSTAGE) begin
         st  = (tn > tuse) ? 1 : 0;
         sel = (tn == 0) ? best : 0;
      end
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
   endtask

   task automatic set_d(input bit v, input int rs, input int rt, input int tur, input int tut,
                        input int dst, input int tnew, input bit frz);
      bus.d_valid   = v;
      bus.d_rs      = 5'(rs);
      bus.d_rt      = 5'(rt);
      bus.d_tuse_rs = 2'(tur);
      bus.d_tuse_rt = 2'(tut);
      bus.d_dst     = 5'(dst);
      bus.d_tnew    = 2'(tnew);
      bus.freeze    = frz;
   endtask

   // Check current outputs against the model, then advance one clock (starts/ends at negedge).
   task automatic cyc(input string tag);
      int s_rs, f_rs, s_rt, f_rt;
      bit est;
      #1;
      ref_src(int'(bus.d_rs), int'(bus.d_tuse_rs), bus.d_valid, s_rs, f_rs);
      ref_src(int'(bus.d_rt), int'(bus.d_tuse_rt), bus.d_valid, s_rt, f_rt);
      est = (s_rs != 0) || (s_rt != 0);
      chk({tag, "_stall"}, 32'(bus.stall), 32'(est));
      chk({tag, "_fwd_rs"}, 32'(bus.fwd_rs_sel), f_rs);
      chk({tag, "_fwd_rt"}, 32'(bus.fwd_rt_sel), f_rt);
`ifdef HAZ_STATS_EN
      chk({tag, "_cnt"}, stall_cnt, m_cnt);
`endif
      @(posedge clk);
      if (!bus.freeze) begin
         adv++;
         if (!est && bus.d_valid && bus.d_dst != 0)
            prods.push_back('{int'(bus.d_dst), int'(bus.d_tnew), adv});
         if (est) m_cnt++;
      end
      while (prods.size() > 0 && adv - prods[0].entry + 1 > NSTAGE)
         void'(prods.pop_front());
      @(negedge clk);
   endtask

   task automatic flush();
      repeat (NSTAGE + 1) begin
         set_d(0, 0, 0, TUSE_NONE, TUSE_NONE, 0, 0, 0);
         cyc("idle");
      end
   endtask

   initial begin
      total  = 0;
      passed = 0;
      model_reset();
      rst_n = 1'b0;
      set_d(1, 8, 8, 0, 0, 0, 0, 0);
      #12;
      chk("rst_stall", 32'(bus.stall), 0);
      chk("rst_fwd_rs", 32'(bus.fwd_rs_sel), 0);
`ifdef HAZ_STATS_EN
      chk("rst_cnt", stall_cnt, 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      // Load-use: one bubble, then the load is still a cycle from ready (no forward yet).
      set_d(1, 0, 0, TUSE_NONE, TUSE_NONE, 8, TNEW_LOAD, 0);
      cyc("s1_lw");
      set_d(1, 8, 0, 1, TUSE_NONE, 10, TNEW_ALU, 0);
      #1 chk("s1_stall_hi", 32'(bus.stall), 1);
      cyc("s1_a");
      #1 chk("s1_stall_lo", 32'(bus.stall), 0);
      chk("s1_fwd_rs", 32'(bus.fwd_rs_sel), 0);
      cyc("s1_b");
      flush();

      // ALU result feeding a branch: stall once, then forward from stage 2.
      set_d(1, 0, 0, TUSE_NONE, TUSE_NONE, 9, TNEW_ALU, 0);
      cyc("s2_addu");
      set_d(1, 9, 0, 0, TUSE_NONE, 0, 0, 0);
      #1 chk("s2_stall_hi", 32'(bus.stall), 1);
      cyc("s2_a");
      #1 chk("s2_stall_lo", 32'(bus.stall), 0);
      chk("s2_fwd_rs", 32'(bus.fwd_rs_sel), 2);
      cyc("s2_b");
      flush();

      // Two writers of $5 in stages 1 and 3: the newest one forwards.
      set_d(1, 0, 0, TUSE_NONE, TUSE_NONE, 5, 0, 0);
      cyc("s3_w1");
      set_d(0, 0, 0, TUSE_NONE, TUSE_NONE, 0, 0, 0);
      cyc("s3_bub");
      set_d(1, 0, 0, TUSE_NONE, TUSE_NONE, 5, 0, 0);
      cyc("s3_w2");
      set_d(1, 5, 5, 0, 0, 0, 0, 0);
      #1 chk("s3_fwd_rs", 32'(bus.fwd_rs_sel), 1);
      chk("s3_fwd_rt", 32'(bus.fwd_rt_sel), 1);
      chk("s3_stall", 32'(bus.stall), 0);
      cyc("s3_rd");
      flush();

      // Register 0 never hazards.
      set_d(1, 0, 0, TUSE_NONE, TUSE_NONE, 0, TNEW_LOAD, 0);
      cyc("s4_lw0");
      set_d(1, 0, 0, 0, 0, 7, TNEW_ALU, 0);
      #1 chk("s4_stall", 32'(bus.stall), 0);
      chk("s4_fwd_rs", 32'(bus.fwd_rs_sel), 0);
      cyc("s4_rd");
      flush();

      // Freeze holds a pending load-use stall, then the normal sequence resumes.
      set_d(1, 0, 0, TUSE_NONE, TUSE_NONE, 8, TNEW_LOAD, 0);
      cyc("s5_lw");
      for (int n = 0; n < 3; n++) begin
         set_d(1, 8, 0, 1, TUSE_NONE, 10, TNEW_ALU, 1);
         #1 chk("s5_frz_stall", 32'(bus.stall), 1);
         cyc("s5_frz");
      end
      set_d(1, 8, 0, 1, TUSE_NONE, 10, TNEW_ALU, 0);
      #1 chk("s5_stall_hi", 32'(bus.stall), 1);
      cyc("s5_a");
      #1 chk("s5_stall_lo", 32'(bus.stall), 0);
      chk("s5_fwd_rs", 32'(bus.fwd_rs_sel), 0);
      cyc("s5_b");
      flush();

      // Random decode streams over a small register set to force frequent hazards.
      for (int n = 0; n < 400; n++) begin
         set_d($urandom_range(0, 3) != 0,
               $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 7) == 0);
         cyc("rnd");
      end
      flush();

      // Fill every stage, then reset asynchronously mid-cycle.
      for (int n = 1; n <= NSTAGE; n++) begin
         set_d(1, 0, 0, TUSE_NONE, TUSE_NONE, n, TNEW_LOAD, 0);
         cyc("s6_fill");
      end
      set_d(1, 1, 2, 0, 0, 0, 0, 0);
      #1 chk("s6_pre_stall", 32'(bus.stall), 1);
      chk("s6_pre_fwd_rs", 32'(bus.fwd_rs_sel), 3);
      #2 rst_n = 1'b0;
      #1 chk("s6_rst_stall", 32'(bus.stall), 0);
      chk("s6_rst_fwd_rs", 32'(bus.fwd_rs_sel), 0);
      chk("s6_rst_fwd_rt", 32'(bus.fwd_rt_sel), 0);
`ifdef HAZ_STATS_EN
      chk("s6_rst_cnt", stall_cnt, 0);
`endif
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      cyc("s6_post");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised stall/forward unit for the in-order MIPS pipeline. It is the successor to the per-instruction Tuse/Tnew decode: it consumes decoded D-stage fields and tracks every in-flight producer through NSTAGE post-D stages. It ages each producer's Tnew every cycle and emits the D-stage stall and per-operand forward selects. It sits beside the D/E pipeline register and drives its enable and bubble-insert.

Parameters:
NSTAGE, 3, post-D stages tracked (E, M, W = 1..3); legal range 2..6
RAW, 5, register-address width
TW, 2, width of Tuse/Tnew fields
SELW, 3, forward-select width; must satisfy 2**SELW > NSTAGE

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
d_valid  in  1  D holds a real instruction (0 = bubble)
d_rs  in  RAW  source 1 address
d_rt  in  RAW  source 2 address
d_tuse_rs  in  TW  cycles until rs is needed
d_tuse_rt  in  TW  cycles until rt is needed
d_dst  in  RAW  destination address (0 = none)
d_tnew  in  TW  Tnew on entry to stage 1
freeze  in  1  external hold of the whole pipe (e.g. mult busy)
stall  out  1  hold PC and F/D, insert bubble into stage 1
fwd_rs_sel  out  SELW  0 = register file, k = forward from stage k
fwd_rt_sel  out  SELW  as fwd_rs_sel, for rt

Behaviour:
- Per stage k (1..NSTAGE): registers vld[k], dst[k] (RAW bits), tn[k] (TW bits). Reset clears all of them to 0 asynchronously; stall and fwd selects then read 0.
- Match(src, k): vld[k] && dst[k]==src && src!=0. Register 0 never hazards or forwards.
- Newest producer for src: the lowest k with Match(src, k). Only this producer is examined; older matches are ignored.
- Stall: asserted when the newest producer of rs has tn > d_tuse_rs, or the newest producer of rt has tn > d_tuse_rt. Combinational; gated by d_valid.
- Forward select: equals k when the newest producer has tn==0. Otherwise 0, including when there is no producer or the producer is not ready yet but tn <= tuse (a later stage forwards). Forced 0 when d_valid=0.
- Advance on a clock edge with freeze=0:
  - Stage k+1 takes stage k's vld and dst, with tn = sat(tn[k]-1), floor 0.
  - Stage NSTAGE's contents retire.
  - If stall=0, stage 1 takes {d_valid, d_dst, d_tnew}.
  - If stall=1, stage 1 takes a bubble {0, 0, 0}.
- freeze=1: all stage registers hold and stall reads as computed. freeze takes priority over stall.
- d_dst=0 or d_valid=0 enters stage 1 with vld=0.
- Latency: stall and selects reflect the current stage state in the same cycle. The pipe decision takes effect at the next edge.
- Reset mid-operation: all stages are cleared on rst_n falling, independent of clk.

Optional Feature:
HAZ_STATS_EN
- Defined: adds output stall_cnt (32 bits). It increments on every clock edge where stall=1 and freeze=0, wraps at 2**32, and resets to 0.
- Undefined: no port and no counter logic.

Decomposition:
- Package hazard_pkg holds:
  - typedef stage_t {vld, dst, tn}
  - constants TUSE_NONE = 2'd3, TNEW_LOAD = 2'd2, TNEW_ALU = 2'd1
  - function sat_dec
- Sub-module hazard_match, one instance per source operand. It scans the stages for the newest producer and outputs {hit, k, tn}.

Test Plan:
1. lw $8 enters (d_tnew=2); next cycle D=addu rs=$8, tuse_rs=1 -> stall=1 for 1 cycle. Cycle after: lw in stage 2 with tn=1, stall=0, fwd_rs_sel=0. Bubble is seen in stage 1.
2. addu $9 (tnew=1); next cycle beq rs=$9, tuse=0 -> stall=1. Next cycle tn=0 in stage 2 -> stall=0, fwd_rs_sel=2.
3. Stage 1 and stage 3 both write $5 (stage 1 tn=0, stage 3 tn=0); D reads $5 -> fwd_rs_sel=1 (newest wins).
4. lw $0 in flight; D reads $0 with tuse=0 -> stall=0, fwd_rs_sel=0.
5. Stall pending with freeze=1 for 3 cycles -> stage contents unchanged, stall stays 1. After freeze drops, the sequence resumes exactly as in scenario 1.
6. rst_n low mid-run with all stages valid -> stall=0, selects=0 immediately. With HAZ_STATS_EN defined, stall_cnt=0.
